// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use hazard detection.
// One-cycle latency. A load-use hazard stalls decode for one cycle and a bubble is inserted; flush overrides the stall.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [3:0]      id_op,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [XLEN-1:0] id_rs_val,
    input  logic [XLEN-1:0] id_rt_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_use_shamt,
    input  logic [4:0]      id_shamt,
    input  logic [REGW-1:0] id_dst,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            flush,
    input  logic            mem_reg_write,
    input  logic [REGW-1:0] mem_dst,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_dst,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_v1,
    output logic [XLEN-1:0] alu_v2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_dst,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [CNTW-1:0] stall_count
);

    logic            valid_q,     valid_d;
    logic [3:0]      op_q,        op_d;
    logic [REGW-1:0] rs_q,        rs_d;
    logic [REGW-1:0] rt_q,        rt_d;
    logic [XLEN-1:0] rs_val_q,    rs_val_d;
    logic [XLEN-1:0] rt_val_q,    rt_val_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic            use_imm_q,   use_imm_d;
    logic            use_shamt_q, use_shamt_d;
    logic [4:0]      shamt_q,     shamt_d;
    logic [REGW-1:0] dst_q,       dst_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q,  mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [CNTW-1:0] cnt_q,       cnt_d;

    logic            hz;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;

    always_comb begin
        hz = id_valid & valid_q & mem_read_q & (dst_q != '0) &
             ((id_uses_rs & (id_rs == dst_q)) | (id_uses_rt & (id_rt == dst_q)));
        stall_id = hz & ~flush;
    end

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        use_shamt_d = use_shamt_q;
        shamt_d     = shamt_q;
        dst_d       = dst_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        cnt_d       = cnt_q;
        if (flush || hz) begin
            // A bubble zeroes every field so the ALU sees op 0 with zero operands.
            valid_d     = 1'b0;
            op_d        = '0;
            rs_d        = '0;
            rt_d        = '0;
            rs_val_d    = '0;
            rt_val_d    = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            use_shamt_d = 1'b0;
            shamt_d     = '0;
            dst_d       = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (!flush && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            valid_d     = id_valid;
            op_d        = id_op;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rs_val_d    = id_rs_val;
            rt_val_d    = id_rt_val;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            use_shamt_d = id_use_shamt;
            shamt_d     = id_shamt;
            dst_d       = id_dst;
            reg_write_d = id_valid & id_reg_write;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            use_shamt_q <= 1'b0;
            shamt_q     <= '0;
            dst_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            use_shamt_q <= use_shamt_d;
            shamt_q     <= shamt_d;
            dst_q       <= dst_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            cnt_q       <= cnt_d;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        if (mem_reg_write && mem_dst != '0 && mem_dst == rs_q) begin
            fwd_rs = mem_result;
        end else if (wb_reg_write && wb_dst != '0 && wb_dst == rs_q) begin
            fwd_rs = wb_result;
        end else begin
            fwd_rs = rs_val_q;
        end
        if (mem_reg_write && mem_dst != '0 && mem_dst == rt_q) begin
            fwd_rt = mem_result;
        end else if (wb_reg_write && wb_dst != '0 && wb_dst == rt_q) begin
            fwd_rt = wb_result;
        end else begin
            fwd_rt = rt_val_q;
        end
    end

    always_comb begin
        if (use_shamt_q) begin
            alu_v1 = {{(XLEN-5){1'b0}}, shamt_q};
        end else if (op_q[3:2] == 2'b00) begin
            alu_v1 = {{(XLEN-5){1'b0}}, fwd_rs[4:0]};
        end else begin
            alu_v1 = fwd_rs;
        end
        alu_v2        = use_imm_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
    end

    assign ex_valid     = valid_q;
    assign alu_op       = op_q;
    assign ex_dst       = dst_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, load-use stall, flush, operand select, saturation.
// The stall counter is narrowed to 3 bits so saturation is reachable in a short run.
module tb_ex_operand_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [3:0]      id_op;
    logic [REGW-1:0] id_rs, id_rt;
    logic            id_uses_rs, id_uses_rt;
    logic [XLEN-1:0] id_rs_val, id_rt_val, id_imm;
    logic            id_use_imm, id_use_shamt;
    logic [4:0]      id_shamt;
    logic [REGW-1:0] id_dst;
    logic            id_reg_write, id_mem_read, id_mem_write;
    logic            flush;
    logic            mem_reg_write;
    logic [REGW-1:0] mem_dst;
    logic [XLEN-1:0] mem_result;
    logic            wb_reg_write;
    logic [REGW-1:0] wb_dst;
    logic [XLEN-1:0] wb_result;
    logic            stall_id, ex_valid;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_v1, alu_v2, ex_store_data;
    logic [REGW-1:0] ex_dst;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic [CNTW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt), .id_shamt(id_shamt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .alu_op(alu_op),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_use_imm = 0; id_use_shamt = 0;
        id_shamt = 0; id_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0; mem_reg_write = 0; mem_dst = 0; mem_result = 0;
        wb_reg_write = 0; wb_dst = 0; wb_result = 0;
    endtask

    // Decode a load: r5 <= mem[r1 + 4].
    task automatic drive_load();
        idle_inputs();
        id_valid = 1; id_op = 4'b1100; id_rs = 1; id_uses_rs = 1; id_rs_val = 32'h100;
        id_imm = 4; id_use_imm = 1; id_dst = 5; id_reg_write = 1; id_mem_read = 1;
    endtask

    // Decode ADD r7 = r6 + r5, which depends on the load's r5.
    task automatic drive_dependent();
        idle_inputs();
        id_valid = 1; id_op = 4'b1100; id_rs = 6; id_rt = 5; id_uses_rs = 1; id_uses_rt = 1;
        id_rs_val = 3; id_rt_val = 32'hDEAD; id_dst = 7; id_reg_write = 1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_stall_id", 32'(stall_id), 0);
        chk("rst_count", 32'(stall_count), 0);
        reset = 0;
        tick();
        chk("idle_valid", 32'(ex_valid), 0);
        chk("idle_op", 32'(alu_op), 0);
        chk("idle_v1", alu_v1, 0);
        chk("idle_v2", alu_v2, 0);
        chk("idle_store", ex_store_data, 0);
        chk("idle_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        chk("idle_dst", 32'(ex_dst), 0);

        // ADD r3 = r1 + r2
        id_valid = 1; id_op = 4'b1100; id_rs = 1; id_rt = 2; id_uses_rs = 1; id_uses_rt = 1;
        id_rs_val = 5; id_rt_val = 7; id_dst = 3; id_reg_write = 1;
        tick();
        chk("add_v1", alu_v1, 5);
        chk("add_v2", alu_v2, 7);
        chk("add_op", 32'(alu_op), 32'hC);
        chk("add_dst", 32'(ex_dst), 3);
        chk("add_ctrl", {28'b0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 4'b1100);

        // Forwarding priority on rs = 4, with rt = 9 fed from WB independently
        idle_inputs();
        id_valid = 1; id_op = 4'b1100; id_rs = 4; id_rt = 9; id_rs_val = 32'h99; id_rt_val = 32'h44;
        id_dst = 10; id_reg_write = 1;
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_dst = 4; mem_result = 32'h11;
        wb_reg_write = 1; wb_dst = 4; wb_result = 32'h22;
        #1 chk("fwd_mem_prio", alu_v1, 32'h11);
        chk("fwd_rt_latched", alu_v2, 32'h44);
        mem_reg_write = 0;
        #1 chk("fwd_wb", alu_v1, 32'h22);
        wb_dst = 9;
        #1 chk("fwd_rt_wb", alu_v2, 32'h22);
        chk("fwd_rs_latched", alu_v1, 32'h99);

        // r0 source never forwards
        idle_inputs();
        id_valid = 1; id_op = 4'b1100; id_rs = 0; id_rs_val = 32'h55;
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_dst = 0; mem_result = 32'h11;
        wb_reg_write = 1; wb_dst = 0; wb_result = 32'h22;
        #1 chk("r0_no_fwd", alu_v1, 32'h55);

        // Load-use: one-cycle stall, bubble, then forwarded load data
        drive_load();
        tick();
        chk("lw_mem_read", 32'(ex_mem_read), 1);
        drive_dependent();
        #1 chk("lu_stall", 32'(stall_id), 1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_op", 32'(alu_op), 0);
        chk("lu_bubble_v1", alu_v1, 0);
        chk("lu_bubble_v2", alu_v2, 0);
        chk("lu_bubble_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        chk("lu_count", 32'(stall_count), 1);
        chk("lu_stall_drops", 32'(stall_id), 0);
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_dst = 5; mem_result = 32'hABC;
        #1 chk("lu_fwd_v2", alu_v2, 32'hABC);
        chk("lu_v1", alu_v1, 3);
        chk("lu_dst", 32'(ex_dst), 7);
        chk("lu_valid", 32'(ex_valid), 1);
        chk("lu_count_hold", 32'(stall_count), 1);

        // Load-use coinciding with flush: flush wins
        drive_load();
        tick();
        drive_dependent();
        flush = 1;
        #1 chk("fl_stall", 32'(stall_id), 0);
        tick();
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_count", 32'(stall_count), 1);
        flush = 0;

        // Variable shift masks rs; constant shift uses shamt; ORI keeps forwarded rt for store data
        idle_inputs();
        id_valid = 1; id_op = 4'b0001; id_rs = 2; id_rt = 3; id_rs_val = 32'h23; id_rt_val = 32'h10;
        id_dst = 4; id_reg_write = 1;
        tick();
        chk("sllv_v1", alu_v1, 3);
        chk("sllv_v2", alu_v2, 32'h10);
        id_use_shamt = 1; id_shamt = 9;
        tick();
        chk("sll_v1", alu_v1, 9);
        idle_inputs();
        id_valid = 1; id_op = 4'b1101; id_rs = 2; id_rt = 8; id_rs_val = 32'h123; id_rt_val = 32'h40;
        id_imm = 32'hFF; id_use_imm = 1; id_dst = 8; id_reg_write = 1;
        tick();
        idle_inputs();
        wb_reg_write = 1; wb_dst = 8; wb_result = 32'h77;
        #1 chk("ori_v2", alu_v2, 32'hFF);
        chk("ori_store", ex_store_data, 32'h77);
        chk("ori_v1_nomask", alu_v1, 32'h123);

        // Saturation: 7 further stalls push a 3-bit counter past its maximum
        for (int i = 0; i < 7; i++) begin
            drive_load();
            tick();
            drive_dependent();
            tick();
        end
        chk("sat_count", 32'(stall_count), 7);

        // Reset while a stall is pending
        drive_load();
        tick();
        drive_dependent();
        #1 chk("mid_stall", 32'(stall_id), 1);
        reset = 1;
        tick();
        chk("mid_rst_valid", 32'(ex_valid), 0);
        chk("mid_rst_count", 32'(stall_count), 0);
        chk("mid_rst_v1", alu_v1, 0);
        chk("mid_rst_dst", 32'(ex_dst), 0);
        chk("mid_rst_stall", 32'(stall_id), 0);
        chk("mid_rst_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        reset = 0;
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
